// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and rcon helper.
// Imported by the key sequencer, its key_gen interface and rcon generator.
package aes_pkg;
  typedef logic [127:0] aes_128;
  typedef logic [7:0]   aes_byte;

  localparam int      AES_NR    = 10;
  localparam aes_byte RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_RUN,
    KS_HOLD
  } ks_state_e;

  function automatic aes_byte xtime(input aes_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Link between the key-schedule sequencer and aes_key_gen.
// master = sequencer side, slave = key_gen side.
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic    en;
  logic    gen_key;
  logic    next_rnd;
  aes_byte rcon;
  aes_128  key;
  aes_128  key_res;

  modport master (
    output en, gen_key, next_rnd, rcon, key,
    input  key_res
  );

  modport slave (
    input  en, gen_key, next_rnd, rcon, key,
    output key_res
  );
endinterface

// File: rtl/aes_rcon_gen.sv
// Registered AES round constant with load/advance controls.
// Kept separate so the decryption schedule can reuse it.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    nrst,
  input  logic    load_i,
  input  logic    adv_i,
  output aes_byte rcon_o
);
  aes_byte rcon_q;
  aes_byte rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    unique case (1'b1)
      load_i:  rcon_d = RCON_INIT;
      adv_i:   rcon_d = xtime(rcon_q);
      default: rcon_d = rcon_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rcon_q <= '0;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer and round-key bank.
// Steps aes_key_gen through NR rounds and serves keys on a registered port.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KG_LAT = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_i,
  input  aes_128     key_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       keys_valid_o,
  aes_key_sched_ctrl_if.master kg,
  input  logic [3:0] rd_idx_i,
  output aes_128     rd_key_o
);
  localparam int RW = $clog2(NR + 1);
  localparam int CW = (KG_LAT > 1) ? $clog2(KG_LAT) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(NR);
  localparam logic [CW-1:0] C_LAST = CW'(KG_LAT - 1);
  localparam logic [3:0]    RD_MAX = 4'(NR);

  ks_state_e     state_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          kv_q;
  logic          en_q;
  logic          gen_q;
  logic          nxt_q;
  aes_128        mkey_q;
  aes_128        rd_q;
  aes_128        bank_q [NR+1];

  logic          accept;
  logic          hold;
  logic          last;
  logic          wr_en;
  logic [RW-1:0] wr_idx;
  aes_128        wr_data;
  aes_byte       rcon;

  assign accept = (state_q == KS_IDLE) && start_i;
  assign hold   = (state_q == KS_HOLD);
  assign last   = (r_q == R_LAST);

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .nrst   (nrst),
    .load_i (accept),
    .adv_i  (hold && !last),
    .rcon_o (rcon)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= KS_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      en_q    <= 1'b0;
      gen_q   <= 1'b0;
      nxt_q   <= 1'b0;
      mkey_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        KS_IDLE: begin
          if (start_i) begin
            state_q <= KS_RUN;
            mkey_q  <= key_i;
            r_q     <= RW'(1);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            kv_q    <= 1'b0;
            en_q    <= 1'b1;
            gen_q   <= 1'b1;
            nxt_q   <= 1'b0;
          end
        end
        KS_RUN: begin
          if (cnt_q == C_LAST) begin
            state_q <= KS_HOLD;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        KS_HOLD: begin
          if (last) begin
            state_q <= KS_IDLE;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
            busy_q  <= 1'b0;
            gen_q   <= 1'b0;
            nxt_q   <= 1'b0;
          end else begin
            state_q <= KS_RUN;
            r_q     <= r_q + 1'b1;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            nxt_q   <= 1'b1;
          end
        end
        default: state_q <= KS_IDLE;
      endcase
    end
  end

  // Single bank write port: master key on start, key_gen result in HOLD.
  always_comb begin
    wr_en   = accept || hold;
    wr_idx  = accept ? '0 : r_q;
    wr_data = accept ? key_i : kg.key_res;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bank_q <= '{default: '0};
      rd_q   <= '0;
    end else begin
      if (wr_en) begin
        bank_q[wr_idx] <= wr_data;
      end
      rd_q <= (rd_idx_i <= RD_MAX) ? bank_q[rd_idx_i] : '0;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = kv_q;
  assign rd_key_o     = rd_q;
  assign kg.en        = en_q;
  assign kg.gen_key   = gen_q;
  assign kg.next_rnd  = nxt_q;
  assign kg.rcon      = rcon;
  assign kg.key       = mkey_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with a behavioural aes_key_gen.
// Expected keys come from a plain AES-128 expansion computed in the bench.
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  typedef struct {
    int     due;
    aes_128 mk;
  } done_t;

  typedef struct {
    int     due;
    aes_128 val;
    int     idx;
  } rd_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  aes_128     key_in = '0;
  logic [3:0] rd_idx = '0;
  logic       busy;
  logic       done;
  logic       kv;
  aes_128     rd_key;

  aes_key_sched_ctrl_if kg ();

  aes_key_sched_ctrl dut (
    .clk          (clk),
    .nrst         (nrst),
    .start_i      (start),
    .key_i        (key_in),
    .busy_o       (busy),
    .done_o       (done),
    .keys_valid_o (kv),
    .kg           (kg),
    .rd_idx_i     (rd_idx),
    .rd_key_o     (rd_key)
  );

  initial forever #5 clk = ~clk;

  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  done_t   dq[$];
  aes_byte rq[$];
  rd_t     rdq[$];
  aes_128  exp_bank [11];
  aes_byte rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic aes_byte gmul(input aes_byte a, input aes_byte b);
    aes_byte p;
    aes_byte x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the definition: GF(2^8) inverse (a^254) then affine map.
  function automatic aes_byte sbox(input aes_byte a);
    aes_byte v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_128 kround(input aes_128 k, input aes_byte rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]),
         sbox(w3[31:24])};
    w0 ^= t;
    w1 ^= w0;
    w2 ^= w1;
    w3 ^= w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic aes_128 expand(input aes_128 k, input int n);
    aes_128 x;
    x = k;
    for (int i = 0; i < n; i++) x = kround(x, rc_tab[i]);
    return x;
  endfunction

  // aes_key_gen stand-in: two enabled register stages.
  aes_128 kg_st;
  always @(posedge clk) begin
    if (!nrst) begin
      kg_st      <= '0;
      kg.key_res <= '0;
    end else if (kg.en) begin
      kg_st <= kround(kg.next_rnd ? kg.key_res : kg.key,
                      kg.gen_key ? kg.rcon : 8'h00);
      kg.key_res <= kg_st;
    end
  end

  int en_cnt = 0;
  int holds = 0;

  always @(negedge clk) begin : mon
    done_t d;
    rd_t   r;
    if (!nrst) begin
      en_cnt = 0;
      holds  = 0;
    end else begin
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 128'(done), 128'(0));
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 128'(cyc), 128'(d.due));
          chk("done_kv", 128'(kv), 128'(1));
          chk("done_busy", 128'(busy), 128'(0));
          chk("done_en_cnt", 128'(en_cnt), 128'(20));
          chk("done_kg_key", kg.key, d.mk);
        end
        en_cnt = 0;
        holds  = 0;
      end
      if (!busy) begin
        chk("idle_kg", 128'({kg.en, kg.gen_key, kg.next_rnd}), 128'(0));
      end else begin
        chk("busy_gen_key", 128'(kg.gen_key), 128'(1));
        if (kg.en) begin
          en_cnt++;
          chk("next_rnd", 128'(kg.next_rnd), 128'(holds != 0));
        end else begin
          if (rq.size() == 0) chk("hold_unexpected", 128'(busy), 128'(0));
          else chk("hold_rcon", 128'(kg.rcon), 128'(rq.pop_front()));
          holds++;
        end
      end
      if (rdq.size() != 0 && rdq[0].due == cyc) begin
        r = rdq.pop_front();
        chk($sformatf("rd_key[%0d]", r.idx), rd_key, r.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input aes_128 k, input bit acc);
    key_in = k;
    start  = 1'b1;
    if (acc) begin
      dq.push_back('{cyc + 31, k});
      for (int i = 0; i < 10; i++) rq.push_back(rc_tab[i]);
      for (int n = 0; n <= 10; n++) exp_bank[n] = expand(k, n);
    end
    tick();
    start = 1'b0;
    if (acc) begin
      chk("start_busy", 128'(busy), 128'(1));
      chk("start_kv", 128'(kv), 128'(0));
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && dq.size() != 0; i++) tick();
    if (dq.size() != 0) begin
      chk("done_timeout", 128'(dq.size()), 128'(0));
      dq.delete();
      rq.delete();
    end
  endtask

  task automatic rd(input int idx, input aes_128 exp);
    rd_idx = 4'(idx);
    rdq.push_back('{cyc + 1, exp, idx});
    tick();
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(i, (i <= 10) ? exp_bank[i] : '0);
    tick();
  endtask

  function automatic aes_128 rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    aes_128 k;
    aes_128 fips;
    int     due;
    fips = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    for (int n = 0; n <= 10; n++) exp_bank[n] = '0;
    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_kv", 128'(kv), 128'(0));
    chk("rst_kg_en", 128'({kg.en, kg.gen_key, kg.next_rnd}), 128'(0));
    chk("rst_kg_key", kg.key, 128'(0));
    chk("rst_rcon", 128'(kg.rcon), 128'(0));
    chk("rst_rd_key", rd_key, 128'(0));
    nrst = 1'b1;
    tick();

    do_start(fips, 1'b1);
    wait_done();
    rd(1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    rd(10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    rd(0, fips);
    rd(15, '0);
    read_all();

    k = rnd_key();
    do_start(k, 1'b1);
    repeat (8) tick();
    rd(1, exp_bank[1]);
    do_start(rnd_key(), 1'b0);
    chk("ignored_mkey", kg.key, k);
    wait_done();
    read_all();

    do_start(rnd_key(), 1'b1);
    repeat (13) tick();
    nrst = 1'b0;
    dq.delete();
    rq.delete();
    for (int n = 0; n <= 10; n++) exp_bank[n] = '0;
    tick();
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_kv", 128'(kv), 128'(0));
    chk("abort_rd_key", rd_key, 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    nrst = 1'b1;
    repeat (40) tick();
    rd(0, '0);
    rd(5, '0);
    do_start(rnd_key(), 1'b1);
    wait_done();
    read_all();

    for (int t = 0; t < 3; t++) begin
      do_start(rnd_key(), 1'b1);
      wait_done();
      for (int j = 0; j < 5; j++) begin
        due = $urandom_range(15, 0);
        rd(due, (due <= 10) ? exp_bank[due] : '0);
      end
      tick();
    end

    do_start(rnd_key(), 1'b1);
    due = dq[dq.size()-1].due;
    for (int i = 0; i < 60 && cyc < due; i++) tick();
    do_start('0, 1'b1);
    wait_done();
    rd(10, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);
    read_all();

    repeat (3) tick();
    chk("done_q_empty", 128'(dq.size()), 128'(0));
    chk("rcon_q_empty", 128'(rq.size()), 128'(0));
    chk("rd_q_empty", 128'(rdq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
